data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter_if.sv | 41 ++++
 rtl/data_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The arbiter takes the slave view; the requester/memory side takes the master view.
interface data_mem_arbiter_if;
    logic        a_req;
    logic        a_we;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_ack;
    logic        a_err;

    logic        b_req;
    logic        b_we;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic        b_ack;
    logic        b_err;

    logic [31:0] rdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_rdata,
        output a_ack, a_err, b_ack, b_err, rdata,
        output mem_addr, mem_wdata, mem_write, mem_read
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_rdata,
        input  a_ack, a_err, b_ack, b_err, rdata,
        input  mem_addr, mem_wdata, mem_write, mem_read
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter giving the MEM stage (A) and the loader/debug port (B)
// shared access to a single-port data memory: IDLE -> ACCESS -> RESP per access.
module data_mem_arbiter #(
    parameter int MEM_WORDS = 1024
) (
    input  logic               clk,
    input  logic               rst,
    data_mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [32:0] WORD_LIMIT = 33'(MEM_WORDS);

    state_t      state;
    state_t      state_nxt;

    logic        last_b;
    logic        lat_id;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        err_bit;
    logic [31:0] rdata_q;

    logic        grant;
    logic        grant_b;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        in_range;

    // Round-robin: on contention the requester not granted last wins.
    always_comb begin
        grant   = 1'b0;
        grant_b = 1'b0;
        if (bus.a_req && bus.b_req) begin
            grant   = 1'b1;
            grant_b = ~last_b;
        end else if (bus.a_req) begin
            grant   = 1'b1;
        end else if (bus.b_req) begin
            grant   = 1'b1;
            grant_b = 1'b1;
        end
    end

    always_comb begin
        sel_we    = grant_b ? bus.b_we    : bus.a_we;
        sel_addr  = grant_b ? bus.b_addr  : bus.a_addr;
        sel_wdata = grant_b ? bus.b_wdata : bus.a_wdata;
    end

    assign in_range = ({1'b0, lat_addr} < WORD_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant edge: the winner's transaction is frozen; later input churn is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_b    <= 1'b1;
            lat_id    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state == IDLE && grant) begin
            last_b    <= grant_b;
            lat_id    <= grant_b;
            lat_we    <= sel_we;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
        end
    end

    // ACCESS-ending edge: result and error are captured for the RESP cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_bit <= 1'b0;
            rdata_q <= '0;
        end else if (state == ACCESS) begin
            err_bit <= ~in_range;
            rdata_q <= (in_range && !lat_we) ? bus.mem_rdata : '0;
        end
    end

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;
        if (state == ACCESS && in_range) begin
            bus.mem_addr  = lat_addr;
            bus.mem_wdata = lat_wdata;
            bus.mem_write = lat_we;
            bus.mem_read  = ~lat_we;
        end
    end

    always_comb begin
        bus.a_ack = 1'b0;
        bus.a_err = 1'b0;
        bus.b_ack = 1'b0;
        bus.b_err = 1'b0;
        if (state == RESP) begin
            if (lat_id) begin
                bus.b_ack = 1'b1;
                bus.b_err = err_bit;
            end else begin
                bus.a_ack = 1'b1;
                bus.a_err = err_bit;
            end
        end
    end

    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small behavioural word memory
// and hand-computed expected values.
module tb_data_mem_arbiter;

    localparam int MW = 16;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   wr_cnt = 0;
    int   rd_cnt = 0;
    logic [31:0] mem [MW] = '{default: 32'h0};

    data_mem_arbiter_if bus ();

    data_mem_arbiter #(.MEM_WORDS(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = (bus.mem_addr < 32'(MW)) ? mem[bus.mem_addr[3:0]] : 32'h0;

    always @(posedge clk) begin
        if (bus.mem_write) begin
            wr_cnt <= wr_cnt + 1;
            if (bus.mem_addr < 32'(MW)) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
        end
        if (bus.mem_read) rd_cnt <= rd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic access(input string tag, input bit use_b, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic e);
        int n;
        bit got;
        @(negedge clk);
        if (use_b) begin
            bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
        end else begin
            bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (use_b ? bus.b_ack : bus.a_ack) got = 1'b1;
        end
        chk({tag, " latency"}, 32'(n), 32'd2);
        chk({tag, " other_ack"}, 32'(use_b ? bus.a_ack : bus.b_ack), 32'd0);
        rd = bus.rdata;
        e  = use_b ? bus.b_err : bus.a_err;
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          w0;
        int          r0;
        logic [1:0]  exp_ack;

        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
        rst = 1'b0;
        #12;
        chk("rst a_ack",     32'(bus.a_ack), 32'd0);
        chk("rst b_ack",     32'(bus.b_ack), 32'd0);
        chk("rst a_err",     32'(bus.a_err), 32'd0);
        chk("rst b_err",     32'(bus.b_err), 32'd0);
        chk("rst rdata",     bus.rdata, 32'd0);
        chk("rst mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst mem_read",  32'(bus.mem_read), 32'd0);
        chk("rst mem_addr",  bus.mem_addr, 32'd0);
        chk("rst mem_wdata", bus.mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // single write then read
        w0 = wr_cnt;
        access("a_wr5", 1'b0, 1'b1, 32'd5, 32'hDEADBEEF, rd, e);
        chk("a_wr5 err", 32'(e), 32'd0);
        chk("a_wr5 rdata", rd, 32'd0);
        chk("a_wr5 pulses", 32'(wr_cnt - w0), 32'd1);
        chk("a_wr5 mem", mem[5], 32'hDEADBEEF);
        access("a_rd5", 1'b0, 1'b0, 32'd5, 32'h0, rd, e);
        chk("a_rd5 err", 32'(e), 32'd0);
        chk("a_rd5 rdata", rd, 32'hDEADBEEF);
        repeat (3) @(negedge clk);
        chk("rdata hold", bus.rdata, 32'hDEADBEEF);

        // edge address
        access("a_wr15", 1'b0, 1'b1, 32'(MW - 1), 32'h12345678, rd, e);
        chk("a_wr15 err", 32'(e), 32'd0);
        access("a_rd15", 1'b0, 1'b0, 32'(MW - 1), 32'h0, rd, e);
        chk("a_rd15 err", 32'(e), 32'd0);
        chk("a_rd15 rdata", rd, 32'h12345678);

        // out of range
        w0 = wr_cnt;
        r0 = rd_cnt;
        access("b_rd_oor", 1'b1, 1'b0, 32'(MW), 32'h0, rd, e);
        chk("b_rd_oor err", 32'(e), 32'd1);
        chk("b_rd_oor rdata", rd, 32'd0);
        access("b_wr_oor", 1'b1, 1'b1, 32'hFFFFFFFF, 32'h55555555, rd, e);
        chk("b_wr_oor err", 32'(e), 32'd1);
        chk("b_wr_oor rdata", rd, 32'd0);
        chk("oor wr strobes", 32'(wr_cnt - w0), 32'd0);
        chk("oor rd strobes", 32'(rd_cnt - r0), 32'd0);
        chk("oor mem15", mem[15], 32'h12345678);
        chk("oor mem0", mem[0], 32'd0);

        // input churn during ACCESS and RESP
        @(negedge clk);
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 32'd3; bus.a_wdata = 32'h11111111;
        @(negedge clk);
        bus.a_addr = 32'd4; bus.a_wdata = 32'h22222222; bus.a_we = 1'b0;
        #1;
        chk("churn mem_addr", bus.mem_addr, 32'd3);
        chk("churn mem_wdata", bus.mem_wdata, 32'h11111111);
        chk("churn mem_write", 32'(bus.mem_write), 32'd1);
        @(negedge clk);
        chk("churn a_ack", 32'(bus.a_ack), 32'd1);
        bus.a_addr = 32'd9; bus.a_wdata = 32'h33333333;
        bus.a_req = 1'b0;
        @(negedge clk);
        chk("churn mem3", mem[3], 32'h11111111);
        chk("churn mem4", mem[4], 32'd0);
        chk("churn mem9", mem[9], 32'd0);

        // contention from reset: A first, then alternating every 3 cycles
        @(negedge clk);
        rst = 1'b0;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 32'd5;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 32'd15;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_ack = 2'b00;
            if (k == 2 || k == 8) exp_ack = 2'b10;
            if (k == 5 || k == 11) exp_ack = 2'b01;
            chk($sformatf("rr cyc%0d", k), 32'({bus.a_ack, bus.b_ack}), 32'(exp_ack));
            if (k == 2) chk("rr a rdata", bus.rdata, 32'hDEADBEEF);
            if (k == 5) chk("rr b rdata", bus.rdata, 32'h12345678);
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        @(negedge clk);

        // reset in the middle of an ACCESS write
        @(negedge clk);
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 32'd7; bus.a_wdata = 32'hA5A5A5A5;
        @(posedge clk);
        #2;
        chk("midrst pre mem_write", 32'(bus.mem_write), 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst mem_write", 32'(bus.mem_write), 32'd0);
        chk("midrst mem_addr", bus.mem_addr, 32'd0);
        chk("midrst mem_wdata", bus.mem_wdata, 32'd0);
        chk("midrst a_ack", 32'(bus.a_ack), 32'd0);
        bus.a_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst a_ack late", 32'(bus.a_ack), 32'd0);
        rst = 1'b1;
        chk("midrst mem7", mem[7], 32'd0);
        access("post_b_wr7", 1'b1, 1'b1, 32'd7, 32'h0BADF00D, rd, e);
        chk("post_b_wr7 err", 32'(e), 32'd0);
        access("post_a_rd7", 1'b0, 1'b0, 32'd7, 32'h0, rd, e);
        chk("post_a_rd7 rdata", rd, 32'h0BADF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
